viterbi_ber_checker: RTL and testbench

//  Receive-side scoreboard for the encoder/channel/decoder harness. Buffers the bits fed to the

---
 rtl/viterbi_ber_checker.sv | 168 ++++++++++++++++
 tb/tb_viterbi_ber_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_ber_checker.sv
// Receive-side BER scoreboard: buffers encoder input bits, aligns them to the Viterbi
// decoder output, locks onto the stream and counts compared bits / residual errors.
module viterbi_ber_checker #(
  parameter int DEPTH    = 64,
  parameter int CNT_W    = 16,
  parameter int LOCK_RUN = 32,
  parameter int LOSS_RUN = 8,
  parameter int MAX_SLIP = DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tx_valid_i,
  input  logic                     tx_bit_i,
  input  logic                     rx_valid_i,
  input  logic                     rx_bit_i,
  input  logic                     clear_i,
  output logic                     locked_o,
  output logic                     fail_o,
  output logic [$clog2(DEPTH):0]   slip_ct_o,
  output logic [CNT_W-1:0]         bit_ct_o,
  output logic [CNT_W-1:0]         err_ct_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  // state    | meaning
  // S_SEARCH | hunting for alignment; matches pop, mismatches discard the rx bit
  // S_LOCKED | aligned; every compare pops and is counted
  // S_FAIL   | slip budget exhausted; terminal until rst/clear_i
  typedef enum logic [1:0] {S_SEARCH, S_LOCKED, S_FAIL} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  localparam int RW = $clog2(LOCK_RUN + 1);
  localparam int MW = $clog2(LOSS_RUN + 1);

  state_t           r_state, w_state_nxt;
  logic             r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic [RW-1:0]    r_run, w_run_nxt, w_run_inc;
  logic [MW-1:0]    r_miss, w_miss_nxt, w_miss_inc;
  logic [SW-1:0]    r_slip, w_slip_nxt, w_slip_sat;
  logic [CNT_W-1:0] r_bit_ct, w_bit_nxt, w_bit_sat;
  logic [CNT_W-1:0] r_err_ct, w_err_nxt, w_err_sat;
  logic             r_overflow, r_underflow;

  logic w_empty, w_full, w_head, w_cmp, w_match, w_pop, w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == SW'(DEPTH));
  assign w_head  = r_mem[r_rd_ptr];
  assign w_cmp   = rx_valid_i && !w_empty;
  assign w_match = (rx_bit_i == w_head);

  assign w_run_inc  = r_run + 1'b1;
  assign w_miss_inc = r_miss + 1'b1;
  assign w_slip_sat = (r_slip == '1) ? r_slip : r_slip + 1'b1;
  assign w_bit_sat  = (r_bit_ct == '1) ? r_bit_ct : r_bit_ct + 1'b1;
  assign w_err_sat  = (r_err_ct == '1) ? r_err_ct : r_err_ct + 1'b1;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push = tx_valid_i && !clear_i && (!w_full || w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_miss_nxt  = r_miss;
    w_slip_nxt  = r_slip;
    w_bit_nxt   = r_bit_ct;
    w_err_nxt   = r_err_ct;
    w_pop       = 1'b0;
    if (w_cmp) begin
      case (r_state)
        S_SEARCH: begin
          if (w_match) begin
            w_pop = 1'b1;
            if (w_run_inc == RW'(LOCK_RUN)) begin
              w_state_nxt = S_LOCKED;
              w_run_nxt   = '0;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end else begin
            w_run_nxt  = '0;
            w_slip_nxt = w_slip_sat;
            if (w_slip_sat >= SW'(MAX_SLIP)) w_state_nxt = S_FAIL;
          end
        end
        S_LOCKED: begin
          w_pop     = 1'b1;
          w_bit_nxt = w_bit_sat;
          if (w_match) begin
            w_miss_nxt = '0;
          end else begin
            w_err_nxt = w_err_sat;
            if (w_miss_inc == MW'(LOSS_RUN)) begin
              w_state_nxt = S_SEARCH;
              w_run_nxt   = '0;
              w_miss_nxt  = '0;
            end else begin
              w_miss_nxt = w_miss_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_bit_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_SEARCH;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_run       <= '0;
      r_miss      <= '0;
      r_slip      <= '0;
      r_bit_ct    <= '0;
      r_err_ct    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear_i) begin
      r_state     <= S_SEARCH;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_run       <= '0;
      r_miss      <= '0;
      r_slip      <= '0;
      r_bit_ct    <= '0;
      r_err_ct    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_run    <= w_run_nxt;
      r_miss   <= w_miss_nxt;
      r_slip   <= w_slip_nxt;
      r_bit_ct <= w_bit_nxt;
      r_err_ct <= w_err_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (tx_valid_i && w_full && !w_pop) r_overflow  <= 1'b1;
      if (rx_valid_i && w_empty)          r_underflow <= 1'b1;
    end
  end

  assign locked_o    = (r_state == S_LOCKED);
  assign fail_o      = (r_state == S_FAIL);
  assign slip_ct_o   = r_slip;
  assign bit_ct_o    = r_bit_ct;
  assign err_ct_o    = r_err_ct;
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Self-checking bench for viterbi_ber_checker: a behavioural queue model feeds an
// expected-status scoreboard, plus directed end-of-scenario checks.
module tb_viterbi_ber_checker;
  localparam int DEPTH    = 64;
  localparam int CNT_W    = 16;
  localparam int LOCK_RUN = 32;
  localparam int LOSS_RUN = 8;
  localparam int MAX_SLIP = DEPTH;
  localparam int SW       = $clog2(DEPTH) + 1;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int SLIP_MAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst, tx_valid_i, tx_bit_i, rx_valid_i, rx_bit_i, clear_i;
  logic locked_o, fail_o, overflow_o, underflow_o;
  logic [SW-1:0]    slip_ct_o;
  logic [CNT_W-1:0] bit_ct_o, err_ct_o;

  int n_err = 0;
  int n_chk = 0;
  logic [63:0] exp_q [$];

  bit m_q [$];
  int m_state, m_run, m_miss, m_slip, m_bit, m_err;
  bit m_ovf, m_unf;

  always #5 clk = ~clk;

  viterbi_ber_checker #(
    .DEPTH(DEPTH), .CNT_W(CNT_W), .LOCK_RUN(LOCK_RUN), .LOSS_RUN(LOSS_RUN), .MAX_SLIP(MAX_SLIP)
  ) dut (
    .clk(clk), .rst(rst), .tx_valid_i(tx_valid_i), .tx_bit_i(tx_bit_i),
    .rx_valid_i(rx_valid_i), .rx_bit_i(rx_bit_i), .clear_i(clear_i),
    .locked_o(locked_o), .fail_o(fail_o), .slip_ct_o(slip_ct_o),
    .bit_ct_o(bit_ct_o), .err_ct_o(err_ct_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_status();
    return 64'({locked_o, fail_o, slip_ct_o, bit_ct_o, err_ct_o, overflow_o, underflow_o});
  endfunction

  // state encoding in the model: 0 search, 1 locked, 2 fail
  function automatic void model_reset();
    m_q.delete();
    m_state = 0; m_run = 0; m_miss = 0; m_slip = 0; m_bit = 0; m_err = 0;
    m_ovf = 0; m_unf = 0;
  endfunction

  function automatic void model_step(bit tv, bit tb, bit rv, bit rb, bit clr);
    bit popped;
    if (clr) begin
      model_reset();
      return;
    end
    popped = 0;
    if (rv && m_q.size() == 0) m_unf = 1;
    else if (rv) begin
      if (m_state == 0) begin
        if (rb == m_q[0]) begin
          void'(m_q.pop_front()); popped = 1;
          m_run++;
          if (m_run == LOCK_RUN) begin m_state = 1; m_run = 0; end
        end else begin
          m_run = 0;
          if (m_slip < SLIP_MAX) m_slip++;
          if (m_slip >= MAX_SLIP) m_state = 2;
        end
      end else if (m_state == 1) begin
        bit hd;
        hd = m_q.pop_front(); popped = 1;
        if (m_bit < CNT_MAX) m_bit++;
        if (rb != hd) begin
          if (m_err < CNT_MAX) m_err++;
          m_miss++;
          if (m_miss == LOSS_RUN) begin m_state = 0; m_run = 0; m_miss = 0; end
        end else m_miss = 0;
      end
    end
    if (tv) begin
      if (m_q.size() < DEPTH) m_q.push_back(tb);
      else m_ovf = 1;
    end
    if (popped) m_bit = m_bit;
  endfunction

  function automatic logic [63:0] model_status();
    logic l, f;
    l = (m_state == 1);
    f = (m_state == 2);
    return 64'({l, f, SW'(m_slip), CNT_W'(m_bit), CNT_W'(m_err), m_ovf, m_unf});
  endfunction

  task automatic step(input bit tv, input bit tb, input bit rv, input bit rb, input bit clr);
    tx_valid_i = tv; tx_bit_i = tb; rx_valid_i = rv; rx_bit_i = rb; clear_i = clr;
    model_step(tv, tb, rv, rb, clr);
    exp_q.push_back(model_status());
    @(posedge clk);
    #1;
    check("status", dut_status(), exp_q.pop_front());
    tx_valid_i = 0; tx_bit_i = 0; rx_valid_i = 0; rx_bit_i = 0; clear_i = 0;
  endtask

  task automatic run_stream(input int n, input int lag, input int junk, input logic [127:0] flip);
    bit txb [$];
    bit rxb [$];
    bit tv, tbit, rv, rbit;
    int r;
    for (int i = 0; i < n; i++) txb.push_back(1'($urandom_range(0, 1)));
    for (int j = 0; j < junk; j++) rxb.push_back(~txb[0]);
    for (int i = 0; i < n; i++) rxb.push_back(txb[i] ^ flip[i]);
    for (int c = 0; c < lag + rxb.size(); c++) begin
      tv = (c < n);
      tbit = tv ? txb[c] : 1'b0;
      r = c - lag;
      rv = (r >= 0);
      rbit = rv ? rxb[r] : 1'b0;
      step(tv, tbit, rv, rbit, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] fm;
    bit t0, b;
    rst = 1; tx_valid_i = 0; tx_bit_i = 0; rx_valid_i = 0; rx_bit_i = 0; clear_i = 0;
    model_reset();
    #23;
    check("reset", dut_status(), 64'd0);
    rst = 0;
    @(posedge clk); #1;

    // 1: clean stream delayed 5 cycles
    run_stream(100, 5, 0, 128'd0);
    check("t1_locked", 64'(locked_o), 64'd1);
    check("t1_bit_ct", 64'(bit_ct_o), 64'd68);
    check("t1_err_ct", 64'(err_ct_o), 64'd0);
    check("t1_slip", 64'(slip_ct_o), 64'd0);

    // 2: three junk bits before the true stream
    step(0, 0, 0, 0, 1);
    check("t2_clear", dut_status(), 64'd0);
    run_stream(100, 5, 3, 128'd0);
    check("t2_slip", 64'(slip_ct_o), 64'd3);
    check("t2_bit_ct", 64'(bit_ct_o), 64'd68);
    check("t2_err_ct", 64'(err_ct_o), 64'd0);

    // 3: two isolated flips while locked
    step(0, 0, 0, 0, 1);
    fm = '0; fm[50] = 1'b1; fm[60] = 1'b1;
    run_stream(100, 5, 0, fm);
    check("t3_err_ct", 64'(err_ct_o), 64'd2);
    check("t3_locked", 64'(locked_o), 64'd1);

    // 4a: stream ends right after the 8th consecutive flip
    step(0, 0, 0, 0, 1);
    fm = '0;
    for (int i = 50; i < 58; i++) fm[i] = 1'b1;
    run_stream(58, 5, 0, fm);
    check("t4a_locked", 64'(locked_o), 64'd0);
    check("t4a_err_ct", 64'(err_ct_o), 64'd8);
    check("t4a_bit_ct", 64'(bit_ct_o), 64'd26);

    // 4: same burst, then relock on the remaining bits
    step(0, 0, 0, 0, 1);
    run_stream(100, 5, 0, fm);
    check("t4_relocked", 64'(locked_o), 64'd1);
    check("t4_err_ct", 64'(err_ct_o), 64'd8);
    check("t4_bit_ct", 64'(bit_ct_o), 64'd36);

    // 5: every rx bit mismatches the head until FAIL
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < MAX_SLIP - 1; i++) step(0, 0, 1, 1, 0);
    check("t5_pre_fail", 64'(fail_o), 64'd0);
    step(0, 0, 1, 1, 0);
    check("t5_fail", 64'(fail_o), 64'd1);
    check("t5_slip", 64'(slip_ct_o), 64'd64);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0);
    check("t5_terminal", 64'(fail_o), 64'd1);
    check("t5_slip_hold", 64'(slip_ct_o), 64'd64);
    step(1, 1, 1, 1, 1);
    check("t5_clear", dut_status(), 64'd0);

    // 6: fill FIFO, push+pop at full, then overflow
    t0 = 0;
    for (int i = 0; i < DEPTH; i++) begin
      b = 1'($urandom_range(0, 1));
      if (i == 0) t0 = b;
      step(1, b, 0, 0, 0);
    end
    check("t6_full_no_ovf", 64'(overflow_o), 64'd0);
    step(1, 1, 1, t0, 0);
    check("t6_pushpop_full", 64'(overflow_o), 64'd0);
    step(1, 0, 0, 0, 0);
    check("t6_overflow", 64'(overflow_o), 64'd1);

    // asynchronous reset mid-cycle
    rst = 1;
    #2;
    check("t6_async_rst", dut_status(), 64'd0);
    model_reset();
    rst = 0;
    step(0, 0, 1, 0, 0);
    check("t6_underflow", 64'(underflow_o), 64'd1);
    check("t6_unf_counters", 64'({slip_ct_o, bit_ct_o, err_ct_o, locked_o}), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
